// File: rtl/ep2_stream_src.sv
// ep2_stream_src: EP2 test-pattern source (const/counter/PRBS/loopback) with PRBS RX checker
module ep2_stream_src #(
  parameter logic [7:0] PATTERN_CONST = 8'hEF,
  parameter int         LB_DEPTH      = 16
) (
  input  logic        PHY_CLKOUT,
  input  logic        RESET,
  input  logic        i_busreset,
  input  logic        i_enable,
  input  logic [1:0]  i_mode,
  input  logic        i_tx_afull,
  output logic        o_tx_dval,
  output logic [7:0]  o_tx_data,
  input  logic        i_rx_dval,
  input  logic [7:0]  i_rx_data,
  output logic        o_rx_rdy,
  output logic [31:0] o_tx_cnt,
  output logic [15:0] o_rx_err_cnt,
  output logic [1:0]  o_state
);
  localparam int AW = $clog2(LB_DEPTH);
  localparam logic [1:0] M_CONST = 2'b00, M_CNT = 2'b01, M_PRBS = 2'b10, M_LB = 2'b11;
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, STALL = 2'b10} state_t;
  state_t        state_q, state_d;
  logic [1:0]    mode_q;
  logic [7:0]    cnt_q, lfsr_q, chk_q, data_q, byte_d;
  logic          dval_q, rdy_q, full_q;
  logic [31:0]   tx_cnt_q;
  logic [15:0]   err_q;
  logic [7:0]    mem_q [LB_DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0]   lvl_q, lvl_d;
  logic          active, start, emit, acc, push, pop, mism;

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  // FSM next state; bus reset wins over every other transition
  always_comb begin
    state_d = i_busreset ? IDLE :
              (state_q == IDLE) ? (i_enable ? RUN : IDLE) :
              !i_enable ? IDLE :
              i_tx_afull ? STALL : RUN;
  end

  // FSM state register
  always_ff @(posedge PHY_CLKOUT or posedge RESET)
    if (RESET) state_q <= IDLE;
    else       state_q <= state_d;

  // Emit/accept qualifiers; emitting from STALL when afull drops keeps the gap equal to the afull pulse
  always_comb begin
    active   = state_q != IDLE;
    start    = !active && i_enable && !i_busreset;
    o_rx_rdy = rdy_q && !(active && mode_q == M_LB && full_q);
    emit     = active && i_enable && !i_tx_afull && !i_busreset && (mode_q != M_LB || lvl_q != '0);
    acc      = i_rx_dval && o_rx_rdy && active && !i_busreset;
    push     = acc && mode_q == M_LB;
    pop      = emit && mode_q == M_LB;
    mism     = i_rx_data != chk_q;
    lvl_d    = lvl_q + (AW+1)'(push) - (AW+1)'(pop);
    byte_d   = mode_q == M_CONST ? PATTERN_CONST :
               mode_q == M_CNT   ? cnt_q :
               mode_q == M_PRBS  ? lfsr_q : mem_q[rp_q];
  end

  // Ready stays low only while RESET is held
  always_ff @(posedge PHY_CLKOUT or posedge RESET)
    if (RESET) rdy_q <= 1'b0;
    else       rdy_q <= 1'b1;

  // Pattern generators, checker, counters and loopback pointers
  always_ff @(posedge PHY_CLKOUT or posedge RESET)
    if (RESET) begin
      mode_q   <= M_CONST;
      cnt_q    <= '0;
      lfsr_q   <= 8'hFF;
      chk_q    <= 8'hFF;
      data_q   <= '0;
      dval_q   <= 1'b0;
      tx_cnt_q <= '0;
      err_q    <= '0;
      wp_q     <= '0;
      rp_q     <= '0;
      lvl_q    <= '0;
      full_q   <= 1'b0;
    end else if (i_busreset) begin
      mode_q   <= M_CONST;
      cnt_q    <= '0;
      lfsr_q   <= 8'hFF;
      chk_q    <= 8'hFF;
      data_q   <= '0;
      dval_q   <= 1'b0;
      tx_cnt_q <= '0;
      err_q    <= '0;
      wp_q     <= '0;
      rp_q     <= '0;
      lvl_q    <= '0;
      full_q   <= 1'b0;
    end else begin
      dval_q <= emit;
      if (start) begin
        mode_q <= i_mode;
        cnt_q  <= '0;
        lfsr_q <= 8'hFF;
        chk_q  <= 8'hFF;
      end
      if (emit) begin
        data_q   <= byte_d;
        tx_cnt_q <= tx_cnt_q + 32'd1;
        if (mode_q == M_CNT) cnt_q <= cnt_q + 8'd1;
        if (mode_q == M_PRBS) lfsr_q <= lfsr_next(lfsr_q);
      end
      if (acc && mode_q == M_PRBS) begin
        chk_q <= lfsr_next(chk_q);
        if (mism && err_q != '1) err_q <= err_q + 16'd1;
      end
      if (push) wp_q <= wp_q + AW'(1);
      if (pop) rp_q <= rp_q + AW'(1);
      lvl_q  <= lvl_d;
      full_q <= lvl_d == (AW+1)'(LB_DEPTH);
    end

  // Loopback storage, no reset needed
  always_ff @(posedge PHY_CLKOUT)
    if (push) mem_q[wp_q] <= i_rx_data;

  assign o_tx_dval    = dval_q;
  assign o_tx_data    = data_q;
  assign o_tx_cnt     = tx_cnt_q;
  assign o_rx_err_cnt = err_q;
  assign o_state      = state_q;
endmodule

// File: tb/tb_ep2_stream_src.sv
// tb_ep2_stream_src: directed + random checks of ep2_stream_src against a behavioural model
module tb_ep2_stream_src;
  logic        clk = 0, rst = 1, busreset = 0, en = 0, afull = 0, rxv = 0;
  logic [1:0]  mode = 0;
  logic [7:0]  rxd = 0;
  logic        dval, rdy;
  logic [7:0]  data;
  logic [31:0] txc;
  logic [15:0] errc;
  logic [1:0]  st;
  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  ep2_stream_src dut (
    .PHY_CLKOUT(clk), .RESET(rst), .i_busreset(busreset), .i_enable(en), .i_mode(mode),
    .i_tx_afull(afull), .o_tx_dval(dval), .o_tx_data(data), .i_rx_dval(rxv), .i_rx_data(rxd),
    .o_rx_rdy(rdy), .o_tx_cnt(txc), .o_rx_err_cnt(errc), .o_state(st)
  );

  int          ms, mmode, mcnt, merr, acc_n;
  logic [7:0]  mlfsr, mchk, mdata;
  logic [31:0] mtx;
  logic        mdval, mready, mfull;
  logic [7:0]  mq[$], seen[$], sent[$];

  function automatic logic [7:0] prbs_next(input logic [7:0] v);
    return {v[6:0], ^(v & 8'hB8)};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clear_model(input logic r);
    ms = 0; mmode = 0; mcnt = 0; merr = 0; mlfsr = 8'hFF; mchk = 8'hFF;
    mdata = 0; mtx = 0; mdval = 0; mready = r; mfull = 0; mq.delete();
  endtask

  task automatic step();
    bit act, rn, emit, acc;
    logic [7:0] b;
    act = ms != 0;
    rn  = mready && !(act && mmode == 3 && mfull);
    acc = rxv && rn && act;
    if (busreset) clear_model(1);
    else begin
      emit = act && en && !afull && (mmode != 3 || mq.size() > 0);
      if (acc) acc_n++;
      if (emit) begin
        case (mmode)
          0: b = 8'hEF;
          1: begin b = mcnt[7:0]; mcnt = (mcnt + 1) & 255; end
          2: begin b = mlfsr; mlfsr = prbs_next(mlfsr); end
          default: b = mq.pop_front();
        endcase
        mdata = b;
        mtx++;
      end
      mdval = emit;
      if (acc && mmode == 2) begin
        if (rxd != mchk && merr < 65535) merr++;
        mchk = prbs_next(mchk);
      end
      if (acc && mmode == 3) mq.push_back(rxd);
      mfull = mq.size() == 16;
      if (ms == 0) begin
        if (en) begin ms = 1; mmode = mode; mcnt = 0; mlfsr = 8'hFF; mchk = 8'hFF; end
      end else if (!en) ms = 0;
      else ms = afull ? 2 : 1;
      mready = 1;
    end
    @(posedge clk); #1;
    if (dval) seen.push_back(data);
    check("state", st, ms);
    check("dval", dval, mdval);
    check("data", data, mdata);
    check("rx_rdy", rdy, mready && !(ms != 0 && mmode == 3 && mfull));
    check("tx_cnt", txc, mtx);
    check("err_cnt", errc, merr);
  endtask

  task automatic bus_reset();
    busreset = 1; en = 0; afull = 0; rxv = 0;
    step();
    busreset = 0;
  endtask

  initial begin
    int bad;
    logic [7:0] v;
    clear_model(0);
    #12;
    check("rst_state", st, 0);
    check("rst_dval", dval, 0);
    check("rst_data", data, 0);
    check("rst_rdy", rdy, 0);
    check("rst_txcnt", txc, 0);
    check("rst_errcnt", errc, 0);
    rst = 0;
    step();
    check("rdy_after_rst", rdy, 1);

    // counter mode, 300 enabled cycles
    seen.delete();
    mode = 1; en = 1;
    repeat (300) step();
    bad = 0;
    foreach (seen[i]) if (seen[i] !== 8'(i)) bad++;
    check("ctr_len", seen.size(), 299);
    check("ctr_seq_errors", bad, 0);
    check("ctr_txcnt", txc, 299);
    en = 0;
    step();

    // PRBS with an afull pulse of 5 cycles
    bus_reset();
    seen.delete();
    mode = 2; en = 1;
    repeat (11) step();
    bad = 0;
    afull = 1;
    repeat (5) begin step(); if (!dval) bad++; end
    afull = 0;
    repeat (5) begin step(); if (!dval) bad++; end
    check("afull_gap_len", bad, 5);
    bad = 0; v = 8'hFF;
    foreach (seen[i]) begin if (seen[i] !== v) bad++; v = prbs_next(v); end
    check("prbs_len", seen.size(), 15);
    check("prbs_seq_errors", bad, 0);

    // loopback fill under afull, then drain
    bus_reset();
    seen.delete(); sent.delete(); acc_n = 0;
    mode = 3; en = 1; afull = 1;
    step();
    rxv = 1;
    repeat (20) begin rxd = 8'($urandom); sent.push_back(rxd); step(); end
    rxv = 0;
    check("lb_accepted", acc_n, 16);
    check("lb_rdy_full", rdy, 0);
    afull = 0;
    repeat (20) step();
    bad = 0;
    foreach (seen[i]) if (seen[i] !== sent[i]) bad++;
    check("lb_len", seen.size(), 16);
    check("lb_order_errors", bad, 0);

    // PRBS checker with byte 7 corrupted
    bus_reset();
    mode = 2; en = 1;
    step();
    v = 8'hFF; rxv = 1;
    for (int i = 0; i < 12; i++) begin
      rxd = (i == 7) ? (v ^ 8'h01) : v;
      step();
      v = prbs_next(v);
    end
    rxv = 0;
    step();
    check("prbs_err_cnt", errc, 1);

    // bus reset mid-run with loopback data buffered
    bus_reset();
    mode = 3; en = 1; afull = 1;
    step();
    rxv = 1;
    repeat (5) begin rxd = 8'($urandom); step(); end
    rxv = 0; afull = 0; busreset = 1;
    step();
    busreset = 0;
    check("br_state", st, 0);
    check("br_txcnt", txc, 0);
    check("br_errcnt", errc, 0);
    bad = 0;
    repeat (6) begin step(); if (dval) bad++; end
    check("br_no_dval", bad, 0);

    // mode change during run is ignored
    bus_reset();
    mode = 1; en = 1;
    step();
    repeat (5) step();
    mode = 0;
    repeat (10) step();
    check("mode_hold_data", data, 14);
    check("mode_hold_txcnt", txc, 15);
    en = 0;
    step();
    check("mode_hold_idle", st, 0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      busreset = $urandom_range(63) == 0;
      en = $urandom_range(7) != 0;
      mode = 2'($urandom_range(3));
      afull = $urandom_range(3) == 0;
      rxv = 1'($urandom_range(1));
      rxd = 8'($urandom);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ep2_stream_src.md
EP2_STREAM_SRC -- requirements
Module: ep2_stream_src

Interface
REQ-001 SHALL provide parameter PATTERN_CONST, default 8'hEF, byte emitted in constant mode.
REQ-002 SHALL provide parameter LB_DEPTH, default 16, loopback buffer depth in bytes (power of two).
REQ-003 SHALL have port PHY_CLKOUT  in  1  60 MHz clock; all logic in this single domain.
REQ-004 SHALL have port RESET  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port i_busreset  in  1  synchronous clear driven by the USB bus-reset indication.
REQ-006 SHALL have port i_enable  in  1  level; 1 = stream running.
REQ-007 SHALL have port i_mode  in  2  pattern select: 00 constant, 01 counter, 10 PRBS-8, 11 loopback.
REQ-008 SHALL have port i_tx_afull  in  1  almost-full backpressure from the EP2 TX FIFO.
REQ-009 SHALL have port o_tx_dval  out  1  byte valid towards the EP2 TX FIFO write side.
REQ-010 SHALL have port o_tx_data  out  8  byte towards the EP2 TX FIFO.
REQ-011 SHALL have port i_rx_dval  in  1  OUT-data byte valid from the EP2 RX FIFO.
REQ-012 SHALL have port i_rx_data  in  8  OUT-data byte.
REQ-013 SHALL have port o_rx_rdy  out  1  ready to accept an RX byte.
REQ-014 SHALL have port o_tx_cnt  out  32  bytes emitted since reset.
REQ-015 SHALL have port o_rx_err_cnt  out  16  PRBS mismatch count.
REQ-016 SHALL have port o_state  out  2  FSM state: 00 IDLE, 01 RUN, 10 STALL.

Function
REQ-017 SHALL implement FSM: IDLE->RUN when i_enable=1; RUN->STALL when i_tx_afull=1; STALL->RUN when i_tx_afull=0; RUN/STALL->IDLE when i_enable=0; i_busreset forces IDLE from any state, with priority over all other transitions.
REQ-018 SHALL latch i_mode on the IDLE->RUN transition; i_mode changes while in RUN/STALL are ignored.
REQ-019 SHALL register o_tx_dval, asserting it for one cycle per emitted byte, only in RUN with i_tx_afull=0 sampled in the same cycle; latency from i_tx_afull rise to o_tx_dval low is exactly 1 cycle.
REQ-020 SHALL, in mode 00, emit PATTERN_CONST on every valid byte.
REQ-021 SHALL, in mode 01, emit 0x00 as the first byte after each IDLE->RUN, incrementing per emitted byte and wrapping 0xFF->0x00; the counter holds across STALL.
REQ-022 SHALL, in mode 10, emit a Fibonacci LFSR x^8+x^6+x^5+x^4+1 seeded 0xFF on IDLE->RUN; the current value is emitted, then the LFSR advances; it holds across STALL.
REQ-023 SHALL, in mode 11, emit bytes popped from a LB_DEPTH-entry loopback FIFO in arrival order; o_tx_dval requires FIFO non-empty, and no pop occurs on an empty FIFO.
REQ-024 SHALL drive o_rx_rdy=1 in modes 00/01/10 and in IDLE; in mode 11, o_rx_rdy=0 when the loopback FIFO is full (registered full flag).
REQ-025 SHALL push i_rx_data into the loopback FIFO only when i_rx_dval & o_rx_rdy in mode 11; simultaneous push and pop SHALL keep occupancy unchanged, and the write pointer SHALL wrap modulo LB_DEPTH.
REQ-026 SHALL, in mode 10, check each accepted RX byte against an independent checker LFSR (same polynomial, seed 0xFF on IDLE->RUN), increment o_rx_err_cnt on mismatch, and saturate it at 0xFFFF; the checker advances per accepted byte regardless of match.
REQ-027 SHALL discard RX bytes in modes 00/01 and in IDLE without effect on any counter.
REQ-028 SHALL increment o_tx_cnt per emitted byte, wrap it at 2^32, and hold it across IDLE.

Reset
REQ-029 SHALL, on RESET: o_state=IDLE, o_tx_dval=0, o_tx_data=0x00, o_rx_rdy=0, o_tx_cnt=0, o_rx_err_cnt=0, loopback FIFO empty, LFSRs=0xFF, latched mode=00; o_rx_rdy SHALL go to 1 on the first clock after RESET deasserts.
REQ-030 SHALL, on i_busreset (one cycle), apply the same values as RESET except o_rx_rdy=1, with effect visible on the next clock edge, including mid-packet and mid-STALL.

Verification
REQ-031 SHALL cover: mode 01, enable, afull=0 for 300 cycles -> bytes 0x00..0xFF, 0x00.. contiguous, o_tx_cnt=299 after the last byte.
REQ-032 SHALL cover: mode 10 running, afull pulsed high for 5 cycles -> dval low exactly 5 cycles starting 1 cycle later, LFSR sequence continuous (0xFF first, no skipped value).
REQ-033 SHALL cover: mode 11, afull held 1, 20 RX bytes offered -> 16 accepted, o_rx_rdy=0; release afull -> those 16 bytes emitted in order.
REQ-034 SHALL cover: mode 10, RX stream equal to the PRBS with byte 7 corrupted -> o_rx_err_cnt=1.
REQ-035 SHALL cover: i_busreset mid-RUN in mode 11 with 5 bytes buffered -> IDLE, FIFO empty, counters 0, no further dval.
REQ-036 SHALL cover: i_mode changed 01->00 during RUN -> counter pattern continues until i_enable drops.
